// File: rtl/memory_arbiter.sv
// Shares one 128-bit main-memory block port between the I-cache (read) and D-cache (read/write-back).
// Define ARB_ROUND_ROBIN_EN for round-robin tie-breaking; default build uses fixed D-priority.
module memory_arbiter #(
  parameter int ADDR_W = 28,
  parameter int DATA_W = 128
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              I_MEM_READ,
  input  logic [ADDR_W-1:0] I_MEM_ADDRESS,
  output logic [DATA_W-1:0] I_MEM_READDATA,
  output logic              I_MEM_BUSYWAIT,
  input  logic              D_MEM_READ,
  input  logic              D_MEM_WRITE,
  input  logic [ADDR_W-1:0] D_MEM_ADDRESS,
  input  logic [DATA_W-1:0] D_MEM_WRITEDATA,
  output logic [DATA_W-1:0] D_MEM_READDATA,
  output logic              D_MEM_BUSYWAIT,
  output logic              MEM_READ,
  output logic              MEM_WRITE,
  output logic [ADDR_W-1:0] MEM_ADDRESS,
  output logic [DATA_W-1:0] MEM_WRITEDATA,
  input  logic [DATA_W-1:0] MEM_READDATA,
  input  logic              MEM_BUSYWAIT,
  output logic [1:0]        GRANT
);

  typedef enum logic [1:0] {IDLE, GRANT_I, GRANT_D, RELEASE} state_t;

  state_t state, state_nxt;
  logic   issued;
  logic   req_i, req_d, d_is_rd, active, own_req, done, pick_d;

  assign req_i   = I_MEM_READ;
  assign req_d   = D_MEM_READ | D_MEM_WRITE;
  assign d_is_rd = D_MEM_READ & ~D_MEM_WRITE;
  // Reset masks the grant so nothing reaches memory while it is held low.
  assign active  = RESET & ((state == GRANT_I) | (state == GRANT_D));
  assign own_req = (state == GRANT_D) ? req_d : req_i;
  assign done    = active & issued & ~MEM_BUSYWAIT & own_req;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_d;
  assign pick_d = req_d & (~req_i | ~last_d);

  always_ff @(posedge CLK) begin
    if (!RESET)    last_d <= 1'b0;
    else if (done) last_d <= (state == GRANT_D);
  end
`else
  assign pick_d = req_d;
`endif

  always_comb begin
    state_nxt     = state;
    MEM_READ      = 1'b0;
    MEM_WRITE     = 1'b0;
    MEM_ADDRESS   = '0;
    MEM_WRITEDATA = '0;
    case (state)
      IDLE: begin
        if (pick_d)     state_nxt = GRANT_D;
        else if (req_i) state_nxt = GRANT_I;
      end
      GRANT_I, GRANT_D: begin
        if (done)          state_nxt = RELEASE;
        else if (!own_req) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (active) begin
      if (state == GRANT_D) begin
        MEM_READ      = d_is_rd;
        MEM_WRITE     = D_MEM_WRITE;
        MEM_ADDRESS   = D_MEM_ADDRESS;
        MEM_WRITEDATA = D_MEM_WRITEDATA;
      end else begin
        MEM_READ      = I_MEM_READ;
        MEM_ADDRESS   = I_MEM_ADDRESS;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state          <= IDLE;
      issued         <= 1'b0;
      I_MEM_READDATA <= '0;
      D_MEM_READDATA <= '0;
    end else begin
      state  <= state_nxt;
      // Set after the first grant cycle so that cycle's MEM_BUSYWAIT is ignored.
      issued <= active & (state_nxt == state);
      if (done && state == GRANT_I)            I_MEM_READDATA <= MEM_READDATA;
      if (done && state == GRANT_D && d_is_rd) D_MEM_READDATA <= MEM_READDATA;
    end
  end

  assign I_MEM_BUSYWAIT = req_i & ~(done & (state == GRANT_I));
  assign D_MEM_BUSYWAIT = req_d & ~(done & (state == GRANT_D));
  assign GRANT          = {state == GRANT_D, state == GRANT_I};

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter: transaction-level model checked every cycle plus literal spot checks.
module tb_memory_arbiter;
  localparam int AW = 28;
  localparam int DW = 128;

  logic          CLK = 1'b0;
  logic          RESET;
  logic          I_MEM_READ, D_MEM_READ, D_MEM_WRITE;
  logic [AW-1:0] I_MEM_ADDRESS, D_MEM_ADDRESS, MEM_ADDRESS;
  logic [DW-1:0] I_MEM_READDATA, D_MEM_READDATA, D_MEM_WRITEDATA, MEM_WRITEDATA, MEM_READDATA;
  logic          I_MEM_BUSYWAIT, D_MEM_BUSYWAIT, MEM_READ, MEM_WRITE, MEM_BUSYWAIT;
  logic [1:0]    GRANT;

  memory_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .CLK(CLK), .RESET(RESET),
    .I_MEM_READ(I_MEM_READ), .I_MEM_ADDRESS(I_MEM_ADDRESS),
    .I_MEM_READDATA(I_MEM_READDATA), .I_MEM_BUSYWAIT(I_MEM_BUSYWAIT),
    .D_MEM_READ(D_MEM_READ), .D_MEM_WRITE(D_MEM_WRITE), .D_MEM_ADDRESS(D_MEM_ADDRESS),
    .D_MEM_WRITEDATA(D_MEM_WRITEDATA), .D_MEM_READDATA(D_MEM_READDATA),
    .D_MEM_BUSYWAIT(D_MEM_BUSYWAIT),
    .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE), .MEM_ADDRESS(MEM_ADDRESS),
    .MEM_WRITEDATA(MEM_WRITEDATA), .MEM_READDATA(MEM_READDATA), .MEM_BUSYWAIT(MEM_BUSYWAIT),
    .GRANT(GRANT)
  );

  always #5 CLK = ~CLK;

  // Main memory: busy for `lat` cycles of an active access (plus an override).
  int            lat = 1;
  int            mcnt = 0;
  logic          force_busy = 1'b0;
  logic [DW-1:0] mem_data = '0;
  always @(posedge CLK) mcnt <= (MEM_READ || MEM_WRITE) ? mcnt + 1 : 0;
  assign MEM_BUSYWAIT = force_busy | ((MEM_READ | MEM_WRITE) & (mcnt < lat));
  assign MEM_READDATA = mem_data;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;
  bit i_done = 1'b0, d_done = 1'b0;

  task automatic lit(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Model: owner 0=none 1=I 2=D, age = grant cycles elapsed, rel = dead cycle pending.
  int            m_own = 0, m_age = 0, m_last = 1;
  bit            m_rel = 1'b0;
  logic [DW-1:0] m_ird = '0, m_drd = '0;

  initial begin
    forever begin
      @(negedge CLK);
      begin
        bit rq_i, rq_d, o_req, dn, e_rd, e_wr;
        logic [AW-1:0] e_ad;
        logic [DW-1:0] e_wd;
        rq_i  = I_MEM_READ;
        rq_d  = D_MEM_READ | D_MEM_WRITE;
        o_req = (m_own == 1) ? rq_i : (m_own == 2) ? rq_d : 1'b0;
        dn    = RESET && m_own != 0 && m_age > 0 && !MEM_BUSYWAIT && o_req;
        e_rd  = RESET && ((m_own == 1 && rq_i) || (m_own == 2 && D_MEM_READ && !D_MEM_WRITE));
        e_wr  = RESET && m_own == 2 && D_MEM_WRITE;
        e_ad  = (m_own == 1) ? I_MEM_ADDRESS : (m_own == 2) ? D_MEM_ADDRESS : '0;
        e_wd  = (m_own == 2) ? D_MEM_WRITEDATA : '0;
        if (chk_en) begin
          lit("grant", GRANT, (m_own == 2) ? 2'b10 : (m_own == 1) ? 2'b01 : 2'b00);
          lit("mem_read", MEM_READ, e_rd);
          lit("mem_write", MEM_WRITE, e_wr);
          lit("i_busywait", I_MEM_BUSYWAIT, rq_i && !(dn && m_own == 1));
          lit("d_busywait", D_MEM_BUSYWAIT, rq_d && !(dn && m_own == 2));
          lit("i_readdata", I_MEM_READDATA, m_ird);
          lit("d_readdata", D_MEM_READDATA, m_drd);
          if (RESET) begin
            lit("mem_address", MEM_ADDRESS, e_ad);
            lit("mem_writedata", MEM_WRITEDATA, e_wd);
          end
        end
        i_done = dn && m_own == 1;
        d_done = dn && m_own == 2;
        if (!RESET) begin
          m_own = 0; m_rel = 0; m_age = 0; m_last = 1; m_ird = '0; m_drd = '0;
        end else if (m_rel) begin
          m_rel = 0;
        end else if (m_own != 0) begin
          if (dn) begin
            if (m_own == 1) m_ird = mem_data;
            else if (D_MEM_READ && !D_MEM_WRITE) m_drd = mem_data;
            m_last = m_own; m_own = 0; m_rel = 1;
          end else if (!o_req) m_own = 0;
          else m_age++;
        end else if (rq_i || rq_d) begin
          m_age = 0;
          if (rq_i && rq_d) begin
`ifdef ARB_ROUND_ROBIN_EN
            m_own = (m_last == 2) ? 1 : 2;
`else
            m_own = 2;
`endif
          end else m_own = rq_d ? 2 : 1;
        end
      end
    end
  end

  // One cycle; a requester drops its request after the cycle it completed.
  task automatic step();
    @(posedge CLK); #1;
    if (i_done) I_MEM_READ = 1'b0;
    if (d_done) begin D_MEM_READ = 1'b0; D_MEM_WRITE = 1'b0; end
  endtask

  task automatic run_idle();
    int n = 0;
    while ((I_MEM_READ || D_MEM_READ || D_MEM_WRITE) && n < 40) begin step(); n++; end
    if (n >= 40) begin
      n_cmp++; n_bad++;
      $display("FAIL run_idle: requests still pending after %0d cycles, required 40 or fewer", n);
      I_MEM_READ = 0; D_MEM_READ = 0; D_MEM_WRITE = 0;
    end
    repeat (2) step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    RESET = 0; I_MEM_READ = 0; D_MEM_READ = 0; D_MEM_WRITE = 0;
    I_MEM_ADDRESS = '0; D_MEM_ADDRESS = '0; D_MEM_WRITEDATA = '0;
    @(posedge CLK); #1; chk_en = 1'b1;
    step();
    lit("rst_grant", GRANT, 2'b00);
    lit("rst_i_rd", I_MEM_READDATA, '0);
    lit("rst_d_rd", D_MEM_READDATA, '0);
    RESET = 1;

    // 1: I-only read, memory busy 3 cycles
    step();
    mem_data = {16{8'hA5}}; lat = 3;
    I_MEM_READ = 1; I_MEM_ADDRESS = 28'h0000012;
    step(); lit("t1_grant_c1", GRANT, 2'b01); lit("t1_addr_c1", MEM_ADDRESS, 28'h0000012);
    step(); step(); lit("t1_ibusy_c3", I_MEM_BUSYWAIT, 1'b1);
    step(); lit("t1_ibusy_c4", I_MEM_BUSYWAIT, 1'b0);
    step(); lit("t1_ird_c5", I_MEM_READDATA, {16{8'hA5}}); lit("t1_grant_c5", GRANT, 2'b00);
    run_idle();

    // 2: simultaneous I and D reads; D wins this tie in both modes
    mem_data = {16{8'hD2}}; lat = 1;
    I_MEM_READ = 1; I_MEM_ADDRESS = 28'h0000040;
    D_MEM_READ = 1; D_MEM_ADDRESS = 28'h0000020;
    step(); lit("t2_grant_c1", GRANT, 2'b10); lit("t2_addr_c1", MEM_ADDRESS, 28'h0000020);
    lit("t2_ibusy_c1", I_MEM_BUSYWAIT, 1'b1);
    step(); step();
    lit("t2_grant_c3", GRANT, 2'b00); lit("t2_ibusy_c3", I_MEM_BUSYWAIT, 1'b1);
    lit("t2_drd_c3", D_MEM_READDATA, {16{8'hD2}});
    step(); lit("t2_grant_c4", GRANT, 2'b00);
    step(); lit("t2_grant_c5", GRANT, 2'b01);
    run_idle();
    lit("t2_ird", I_MEM_READDATA, {16{8'hD2}});

    // 3: D write-back with READ also high (write wins), memory busy 2 cycles
    mem_data = {16{8'hEE}}; lat = 2;
    D_MEM_READ = 1; D_MEM_WRITE = 1; D_MEM_ADDRESS = 28'h0000031;
    D_MEM_WRITEDATA = 128'h12345678_9ABCDEF0_0FEDCBA9_87654321;
    step(); lit("t3_wr_c1", MEM_WRITE, 1'b1); lit("t3_rd_c1", MEM_READ, 1'b0);
    lit("t3_wd_c1", MEM_WRITEDATA, 128'h12345678_9ABCDEF0_0FEDCBA9_87654321);
    step(); lit("t3_wr_c2", MEM_WRITE, 1'b1);
    step(); step(); lit("t3_drd", D_MEM_READDATA, {16{8'hD2}});
    run_idle();

    // 4: D write then D read while I waits
    mem_data = {16{8'h4C}}; lat = 1;
    D_MEM_WRITE = 1; D_MEM_ADDRESS = 28'h0000031; D_MEM_WRITEDATA = {4{32'hCAFEF00D}};
    step(); I_MEM_READ = 1; I_MEM_ADDRESS = 28'h0000044;
    step(); step();
    lit("t4_rel_rd", MEM_READ, 1'b0); lit("t4_rel_wr", MEM_WRITE, 1'b0); lit("t4_rel_grant", GRANT, 2'b00);
    D_MEM_READ = 1; D_MEM_ADDRESS = 28'h0000022;
    step(); step();
`ifdef ARB_ROUND_ROBIN_EN
    lit("t4_grant_c5", GRANT, 2'b01);
`else
    lit("t4_grant_c5", GRANT, 2'b10);
`endif
    run_idle();
    lit("t4_ird", I_MEM_READDATA, {16{8'h4C}});
    lit("t4_drd", D_MEM_READDATA, {16{8'h4C}});

    // 5: reset mid GRANT_D with memory busy
    mem_data = {16{8'h5E}}; lat = 1; force_busy = 1;
    D_MEM_READ = 1; D_MEM_ADDRESS = 28'h0000020;
    step(); lit("t5_grant_c1", GRANT, 2'b10);
    step(); RESET = 0; #1;
    lit("t5_rd_rst", MEM_READ, 1'b0); lit("t5_dbusy_rst", D_MEM_BUSYWAIT, 1'b1);
    step();
    lit("t5_grant_c3", GRANT, 2'b00); lit("t5_drd_c3", D_MEM_READDATA, '0);
    lit("t5_ird_c3", I_MEM_READDATA, '0); lit("t5_rd_c3", MEM_READ, 1'b0);
    lit("t5_dbusy_c3", D_MEM_BUSYWAIT, 1'b1);
    RESET = 1; force_busy = 0;
    run_idle();
    lit("t5_drd_after", D_MEM_READDATA, {16{8'h5E}});

    // 6: D aborts before completion, pending I then granted
    mem_data = {16{8'h6F}}; lat = 3;
    D_MEM_READ = 1; D_MEM_ADDRESS = 28'h0000020;
    step(); I_MEM_READ = 1; I_MEM_ADDRESS = 28'h0000044;
    lit("t6_grant_c1", GRANT, 2'b10);
    step(); D_MEM_READ = 0;
    step();
    lit("t6_grant_c3", GRANT, 2'b00); lit("t6_rd_c3", MEM_READ, 1'b0);
    lit("t6_drd_c3", D_MEM_READDATA, {16{8'h5E}}); lit("t6_ibusy_c3", I_MEM_BUSYWAIT, 1'b1);
    step(); lit("t6_grant_c4", GRANT, 2'b01); lit("t6_addr_c4", MEM_ADDRESS, 28'h0000044);
    run_idle();
    lit("t6_ird", I_MEM_READDATA, {16{8'h6F}});

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
